// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : osd_pkg
//  Purpose  : Shared types and default constants for the OSD character
//             renderer: RGB888 pixel type, 12-bit coordinate type, default
//             overlay placement/colour and the per-channel blend helper.
//  Revision : 1.0 - initial release
// ============================================================================
package osd_pkg;

  typedef logic [23:0] rgb888_t;
  typedef logic [11:0] coord_t;

  localparam int unsigned OSD_X_DEFAULT     = 64;
  localparam int unsigned OSD_Y_DEFAULT     = 32;
  localparam int unsigned OSD_W_DEFAULT     = 256;
  localparam int unsigned OSD_H_DEFAULT     = 64;
  localparam rgb888_t     OSD_COLOR_DEFAULT = 24'hFFFFFF;

  localparam coord_t COORD_MAX = 12'hFFF;

  // Half-intensity mix of two pixels, channel by channel: (a>>1)+(b>>1).
  // Each term is at most 7F, so the 8-bit sum never overflows.
  function automatic rgb888_t osd_blend(input rgb888_t pix, input rgb888_t col);
    rgb888_t res;
    for (int c = 0; c < 3; c++) begin
      res[c*8 +: 8] = {1'b0, pix[c*8+1 +: 7]} + {1'b0, col[c*8+1 +: 7]};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/osd_timing_delay.sv
`default_nettype none
// ============================================================================
//  Module   : osd_timing_delay
//  Purpose  : DEPTH-stage shift delay carrying the packed pixel context
//             {hs, vs, de, data, inregion, bitidx} so it lines up with the
//             bitmap word returned by the external ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module osd_timing_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Each stage takes the value of the stage before it; stage 0 takes the input.
  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift register; reset flushes every stage so stale pixels never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/osd_char_render.sv
`default_nettype none
// ============================================================================
//  Module   : osd_char_render
//  Purpose  : Overlays a 1-bpp bitmap (read from an external ROM) onto an
//             RGB888 video stream inside a fixed rectangular region.
//             Latency input->output is ROM_LATENCY+2 clocks on every output.
//             Build option OSD_CHAR_RENDER_BLEND_EN: overlay pixels become a
//             50/50 mix of the input and OSD_COLOR instead of replacing it.
//  Revision : 1.0 - initial release
// ============================================================================
module osd_char_render
  import osd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned OSD_X       = OSD_X_DEFAULT,
  parameter int unsigned OSD_Y       = OSD_Y_DEFAULT,
  parameter int unsigned OSD_W       = OSD_W_DEFAULT,
  parameter int unsigned OSD_H       = OSD_H_DEFAULT,
  parameter rgb888_t     OSD_COLOR   = OSD_COLOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osd_en,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [23:0]           i_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [23:0]           o_data
);

  localparam int unsigned BIT_W          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned WORDS_PER_LINE = OSD_W / DATA_WIDTH;
  localparam int unsigned PIPE_W         = 3 + 24 + 1 + BIT_W;
  // Context must wait for the address register plus the ROM read.
  localparam int unsigned PIPE_DEPTH     = ROM_LATENCY + 1;

  // Region bounds in 13 bits so OSD_X+OSD_W cannot wrap.
  localparam logic [12:0] X_LO  = 13'(OSD_X);
  localparam logic [12:0] X_HI  = 13'(OSD_X + OSD_W);
  localparam logic [12:0] Y_LO  = 13'(OSD_Y);
  localparam logic [12:0] Y_HI  = 13'(OSD_Y + OSD_H);
  localparam coord_t      X_ORG = coord_t'(OSD_X);
  localparam coord_t      Y_ORG = coord_t'(OSD_Y);
  localparam coord_t      DW_C  = coord_t'(DATA_WIDTH);

  // Front-end state
  coord_t                  x_q, x_d;
  coord_t                  y_q, y_d;
  logic                    vs_prev_q, vs_prev_d;
  logic                    de_prev_q, de_prev_d;
  logic                    active_en_q, active_en_d;
  logic                    frame_valid_q, frame_valid_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;

  // Front-end combinational helpers
  logic                    vs_rise;
  logic                    de_fall;
  logic                    in_region;
  coord_t                  rel_x;
  coord_t                  rel_y;
  logic [23:0]             addr_wide;
  logic [BIT_W-1:0]        bit_idx;

  // Delayed pixel context
  logic [PIPE_W-1:0]       pipe_in;
  logic [PIPE_W-1:0]       pipe_out;
  logic                    d_hs, d_vs, d_de, d_inregion;
  rgb888_t                 d_data;
  logic [BIT_W-1:0]        d_bit_idx;

  // Output stage
  logic [DATA_WIDTH-1:0]   rom_shifted;
  logic                    pix_on;
  rgb888_t                 overlay_pix;
  logic                    out_hs_q, out_hs_d;
  logic                    out_vs_q, out_vs_d;
  logic                    out_de_q, out_de_d;
  rgb888_t                 out_data_q, out_data_d;

  // Pixel/line counters, frame-boundary enable capture and ROM address.
  always_comb begin
    vs_rise   = i_vs & ~vs_prev_q;
    de_fall   = de_prev_q & ~i_de;
    rel_x     = x_q - X_ORG;
    rel_y     = y_q - Y_ORG;
    in_region = i_de
              && ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI)
              && ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);
    addr_wide  = 24'(rel_y) * 24'(WORDS_PER_LINE) + 24'(rel_x / DW_C);
    bit_idx    = BIT_W'(rel_x % DW_C);
    rom_addr_d = in_region ? ADDR_WIDTH'(addr_wide) : '0;

    // x holds the index of the current pixel; any blank cycle clears it.
    x_d = '0;
    if (i_de) begin
      x_d = (x_q == COORD_MAX) ? x_q : x_q + 12'd1;
    end

    // Frame start beats a simultaneous end-of-line.
    y_d = y_q;
    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != COORD_MAX)) begin
      y_d = y_q + 12'd1;
    end

    // The enable request is only honoured at a frame boundary.
    active_en_d   = vs_rise ? osd_en : active_en_q;
    frame_valid_d = frame_valid_q | vs_rise;
    vs_prev_d     = i_vs;
    de_prev_d     = i_de;
  end

  assign pipe_in = {i_hs, i_vs, i_de, i_data, in_region, bit_idx};

  osd_timing_delay #(
    .WIDTH (PIPE_W),
    .DEPTH (PIPE_DEPTH)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {d_hs, d_vs, d_de, d_data, d_inregion, d_bit_idx} = pipe_out;

  // Select the bitmap bit (MSB = leftmost pixel) and composite the pixel.
  always_comb begin
    rom_shifted = rom_rd_data << d_bit_idx;
    pix_on      = d_inregion & rom_shifted[DATA_WIDTH-1] & active_en_q & frame_valid_q;
`ifdef OSD_CHAR_RENDER_BLEND_EN
    overlay_pix = osd_blend(d_data, OSD_COLOR);
`else
    overlay_pix = OSD_COLOR;
`endif
    out_hs_d   = d_hs;
    out_vs_d   = d_vs;
    out_de_d   = d_de;
    out_data_d = pix_on ? overlay_pix : d_data;
  end

  // All state and output registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      active_en_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      rom_addr_q    <= '0;
      out_hs_q      <= 1'b0;
      out_vs_q      <= 1'b0;
      out_de_q      <= 1'b0;
      out_data_q    <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      active_en_q   <= active_en_d;
      frame_valid_q <= frame_valid_d;
      rom_addr_q    <= rom_addr_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
      out_de_q      <= out_de_d;
      out_data_q    <= out_data_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign o_hs     = out_hs_q;
  assign o_vs     = out_vs_q;
  assign o_de     = out_de_q;
  assign o_data   = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_osd_char_render.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osd_char_render
//  Purpose  : Self-checking bench for osd_char_render. Two instances
//             (ROM_LATENCY 1 and 2) share one randomized video stream; a
//             frame-level reference model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_osd_char_render;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int OX = 64;
  localparam int OY = 32;
  localparam int OW = 256;
  localparam int OH = 64;
  localparam int NL = 100;
  localparam logic [23:0] COLOR = 24'hFFFFFF;
`ifdef OSD_CHAR_RENDER_BLEND_EN
  localparam logic [23:0] ON_BLACK = 24'h7F7F7F;
`else
  localparam logic [23:0] ON_BLACK = 24'hFFFFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osd_en = 1'b0;
  logic i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [23:0] i_data = '0;

  logic [AW-1:0] rom_addr1, rom_addr2;
  logic [DW-1:0] rom_rd1, rom_rd2, rom_rd2_p;
  logic o_hs1, o_vs1, o_de1, o_hs2, o_vs2, o_de2;
  logic [23:0] o_data1, o_data2;
  logic [DW-1:0] rom [1 << AW];

  always #5 clk = ~clk;

  // External bitmap ROMs with one and two cycles of read latency.
  always @(posedge clk) rom_rd1 <= rom[rom_addr1];
  always @(posedge clk) begin
    rom_rd2_p <= rom[rom_addr2];
    rom_rd2   <= rom_rd2_p;
  end

  osd_char_render #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .osd_en(osd_en), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_data(i_data), .rom_addr(rom_addr1), .rom_rd_data(rom_rd1),
    .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1), .o_data(o_data1));

  osd_char_render #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .osd_en(osd_en), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_data(i_data), .rom_addr(rom_addr2), .rom_rd_data(rom_rd2),
    .o_hs(o_hs2), .o_vs(o_vs2), .o_de(o_de2), .o_data(o_data2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: position within line/frame and frame enable.
  int px = 0, ln = 0;
  bit pvs = 0, pde = 0, m_en = 0, m_valid = 0;

  // Per-cycle history of predicted outputs, indexed by sampling cycle.
  logic [26:0] h_out [16];
  logic [23:0] h_in  [16];
  bit          h_rst [16];
  bit          h_hit [16];
  int          h_probe [16];

  int ovl_dut [2];
  int ovl_ref [2];
  int ovl_rst [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] overlay(input logic [23:0] d);
`ifdef OSD_CHAR_RENDER_BLEND_EN
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = (d[c*8 +: 8] >> 1) + (COLOR[c*8 +: 8] >> 1);
    return r;
`else
    return COLOR;
`endif
  endfunction

  // Compare one instance whose output lags its sampled input by d edges.
  task automatic check_dut(input int u, input int d, input logic [26:0] got);
    bit zero;
    int src;
    string tag;
    tag = (u == 0) ? "out_lat3" : "out_lat4";
    zero = 0;
    for (int j = 0; j <= d; j++) begin
      if (cyc - j < 0) zero = 1;
      else if (h_rst[(cyc - j) % 16]) zero = 1;
    end
    if (zero) begin
      check_val(tag, 32'(got), 32'd0);
    end else begin
      src = (cyc - d) % 16;
      check_val(tag, 32'(got), 32'(h_out[src]));
      if (h_hit[src]) ovl_ref[u]++;
      if (got[23:0] != h_in[src]) begin
        ovl_dut[u]++;
        ovl_rst[u]++;
      end
      if (h_probe[src] == 64) check_val("pix_64_32", 32'(got[23:0]), 32'(ON_BLACK));
      if (h_probe[src] == 95) check_val("pix_95_32", 32'(got[23:0]), 32'(ON_BLACK));
      if (h_probe[src] == 65) check_val("pix_65_32", 32'(got[23:0]), 32'(h_in[src]));
    end
  endtask

  // One clock of stimulus, model prediction and checking.
  task automatic tick(input logic hs, input logic vs, input logic de,
                      input logic [23:0] data, input logic r);
    bit inreg, bitv, hit;
    int addr, probe, idx;
    logic [DW-1:0] word;
    logic [23:0] pix;
    i_hs = hs; i_vs = vs; i_de = de; i_data = data; rst = r;

    inreg = de && px >= OX && px < OX + OW && ln >= OY && ln < OY + OH;
    addr = 0;
    bitv = 0;
    if (inreg) begin
      addr = (ln - OY) * (OW / DW) + (px - OX) / DW;
      word = rom[addr];
      bitv = word[DW - 1 - ((px - OX) % DW)];
    end
    hit = !r && bitv && m_en && m_valid;
    pix = hit ? overlay(data) : data;
    probe = 0;
    if (!r && inreg && m_en && m_valid && ln == 32 && (px == 64 || px == 65 || px == 95))
      probe = px;

    @(posedge clk);
    idx = cyc % 16;
    h_out[idx]   = r ? 27'd0 : {hs, vs, de, pix};
    h_in[idx]    = data;
    h_rst[idx]   = r;
    h_hit[idx]   = hit;
    h_probe[idx] = probe;

    if (r) begin
      px = 0; ln = 0; pvs = 0; pde = 0; m_en = 0; m_valid = 0;
      ovl_rst[0] = 0; ovl_rst[1] = 0;
    end else begin
      if (vs && !pvs) begin
        ln = 0; m_en = osd_en; m_valid = 1;
      end else if (pde && !de && ln < 4095) begin
        ln++;
      end
      px = de ? ((px < 4095) ? px + 1 : px) : 0;
      pvs = vs; pde = de;
    end

    #1;
    check_val("rom_addr_l1", 32'(rom_addr1), r ? 32'd0 : 32'(addr));
    check_val("rom_addr_l2", 32'(rom_addr2), r ? 32'd0 : 32'(addr));
    if (r) check_val("rst_outputs", 32'({o_hs1, o_vs1, o_de1, o_data1}), 32'd0);
    if (!r && de && !(vs && !pvs)) begin
      if (h_in[idx] == data && addr == 511 && inreg)
        check_val("addr_319_95", 32'(rom_addr1), 32'd511);
    end
    check_dut(0, 2, {o_hs1, o_vs1, o_de1, o_data1});
    check_dut(1, 3, {o_hs2, o_vs2, o_de2, o_data2});
    cyc++;
  endtask

  // Overlay pixel counts of the frame just finished.
  task automatic frame_check(input int prev);
    check_val("ovl_count_l1", 32'(ovl_dut[0]), 32'(ovl_ref[0]));
    check_val("ovl_count_l2", 32'(ovl_dut[1]), 32'(ovl_ref[1]));
    for (int u = 0; u < 2; u++) begin
      if (prev == 1) check_val("ovl_kept_after_en_off", 32'(ovl_dut[u] > 0), 32'd1);
      if (prev == 2) check_val("ovl_gone_next_frame", 32'(ovl_dut[u]), 32'd0);
      if (prev == 3) check_val("ovl_after_rst", 32'(ovl_rst[u]), 32'd0);
      if (prev == 4) check_val("ovl_back_after_vs", 32'(ovl_dut[u] > 0), 32'd1);
      ovl_dut[u] = 0; ovl_ref[u] = 0; ovl_rst[u] = 0;
    end
  endtask

  task automatic run_frame(input int f);
    int w;
    logic [23:0] d;
    for (int c = 0; c < 12; c++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    frame_check(f - 1);
    for (int c = 0; c < 16; c++) tick(c < 3, 1'b1, 1'b0, 24'($urandom), 1'b0);
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    for (int l = 0; l < NL; l++) begin
      if (f == 1 && l == 40) osd_en = 1'b0;
      if (f == 2 && l == 10) osd_en = 1'b1;
      if (l == 32 || l == 33 || l == 63 || l == 94 || l == 95) w = 330;
      else if (l >= 32 && l < 96) w = int'($urandom_range(40, 160));
      else w = int'($urandom_range(4, 40));
      for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
      tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
      for (int p = 0; p < w; p++) begin
        d = 24'($urandom);
        if (l == 32 && (p == 64 || p == 95)) d = 24'h000000;
        tick(1'b0, 1'b0, 1'b1, d, (f == 3 && l == 50 && p == 100));
        if (l == 95 && p == 320 && !(f == 3))
          check_val("addr_320_95", 32'(rom_addr1), 32'd0);
      end
      tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
      tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[0] = 32'h80000001;
    for (int u = 0; u < 2; u++) begin
      ovl_dut[u] = 0; ovl_ref[u] = 0; ovl_rst[u] = 0;
    end
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b1);
    osd_en = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(f);
    for (int c = 0; c < 12; c++) tick(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    frame_check(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/osd_char_render.md
OSD_CHAR_RENDER -- requirements
Module: osd_char_render

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning OSD bitmap ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning ROM word width, i.e. pixels per ROM word.
REQ-003 SHALL have parameter ROM_LATENCY, default 1, meaning clocks from rom_addr to valid rom_rd_data; legal values 1 or 2.
REQ-004 SHALL have parameters OSD_X, OSD_Y (defaults 64, 32), meaning the top-left pixel of the overlay region.
REQ-005 SHALL have parameters OSD_W, OSD_H (defaults 256, 64), meaning the region size in pixels; OSD_W is a multiple of DATA_WIDTH.
REQ-006 SHALL have parameter OSD_COLOR, default 24'hFFFFFF, meaning the RGB888 colour of set bitmap bits.
REQ-007 Ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-008 Ports: osd_en in 1, overlay enable request.
REQ-009 Ports: i_hs, i_vs, i_de in 1 each, active-high input timing.
REQ-010 Ports: i_data in 24, RGB888 input pixel.
REQ-011 Ports: rom_addr out ADDR_WIDTH, bitmap ROM address.
REQ-012 Ports: rom_rd_data in DATA_WIDTH, bitmap ROM word.
REQ-013 Ports: o_hs, o_vs, o_de out 1 each, delayed timing.
REQ-014 Ports: o_data out 24, composited pixel.

Function
REQ-015 Pixel counter x (12 bit) SHALL increment on each i_de=1 cycle, clear on the cycle after i_de falls, and saturate at 4095.
REQ-016 Line counter y (12 bit) SHALL increment on each i_de falling edge, clear on the i_vs rising edge, and saturate at 4095.
REQ-017 An i_vs rising edge together with an i_de falling edge in the same cycle SHALL give y=0, i.e. clear wins.
REQ-018 In-region SHALL mean i_de=1, OSD_X<=x<OSD_X+OSD_W, and OSD_Y<=y<OSD_Y+OSD_H.
REQ-019 When in-region, rom_addr SHALL be registered as (y-OSD_Y)*(OSD_W/DATA_WIDTH)+((x-OSD_X)/DATA_WIDTH); when not in-region, rom_addr SHALL be 0.
REQ-020 Bit index (x-OSD_X) mod DATA_WIDTH and the in-region flag SHALL be pipelined alongside i_hs/i_vs/i_de/i_data.
REQ-021 Bit index 0 SHALL select rom_rd_data[DATA_WIDTH-1], so the MSB is the leftmost pixel.
REQ-022 Total latency from i_* to o_* SHALL be exactly ROM_LATENCY+2 clocks for all outputs: address register, ROM, and output register.
REQ-023 o_data SHALL be OSD_COLOR when the delayed in-region flag=1, the selected bit=1, and active_en=1; otherwise o_data SHALL be the delayed i_data.
REQ-024 active_en SHALL sample osd_en only on an i_vs rising edge, so enable changes never take effect mid-frame.
REQ-025 Overlay SHALL stay suppressed after reset until the first i_vs rising edge sets frame_valid.
REQ-026 o_hs, o_vs, o_de SHALL be pure delayed copies and SHALL never be altered by the overlay.

Reset
REQ-027 On rst=1 at a clk edge, x, y, rom_addr, active_en, frame_valid, all pipeline stages, o_hs, o_vs, o_de, and o_data SHALL become 0.
REQ-028 A reset asserted mid-frame SHALL cause output timing to restart from the first input sampled after release, with no overlay until the next i_vs rising edge.

Configuration
REQ-029 With OSD_CHAR_RENDER_BLEND_EN defined, overlay pixels SHALL be, per 8-bit channel, (i_data_ch>>1)+(OSD_COLOR_ch>>1).
REQ-030 Without OSD_CHAR_RENDER_BLEND_EN, overlay pixels SHALL replace the input with OSD_COLOR.
REQ-031 Latency SHALL be identical with and without OSD_CHAR_RENDER_BLEND_EN.

Structure
REQ-032 Package osd_pkg SHALL hold the RGB888 pixel typedef, the 12-bit coordinate typedef, and the default OSD_X/OSD_Y/OSD_W/OSD_H/OSD_COLOR constants.
REQ-033 One sub-module, osd_timing_delay, SHALL implement the N-stage shift delay of {hs, vs, de, data, inregion, bitidx}.
REQ-034 The ROM instance SHALL sit outside this block and be connected through rom_addr/rom_rd_data.

Verification
REQ-035 Test 1: 640x480 timing, osd_en=1 before the first vs, ROM word 0=32'h80000001. Required: pixel (64,32) and pixel (95,32) are FFFFFF; pixel (65,32) passes i_data.
REQ-036 Test 2: ROM_LATENCY=1, then 2. Required: every o_* equals i_* delayed by exactly 3, then 4, clocks.
REQ-037 Test 3: osd_en toggled to 0 at line 40. Required: the overlay stays visible through the frame and disappears from the next frame.
REQ-038 Test 4: rst pulsed at line 50 (osd_en=1, non-zero data). Required: outputs are 0 that cycle; no FFFFFF pixel appears until after the next vs rising edge.
REQ-039 Test 5: probe rom_addr at pixel (319,95) and pixel (320,95). Required: rom_addr=511 at (319,95); rom_addr=0 at (320,95), which is out of region.
REQ-040 Test 6: OSD_CHAR_RENDER_BLEND_EN defined, i_data=24'h000000, bit set. Required: o_data=24'h7F7F7F.
